// File: rtl/riscv_lsu_if.sv
// rtl/riscv_lsu_if.sv - EX request, data-cache and writeback signals of the load/store unit
`ifndef CACHE_D_WRITE_LEN
`define CACHE_D_WRITE_LEN 2
`define CACHE_D_WRITE_SB 2'd1
`define CACHE_D_WRITE_SH 2'd2
`define CACHE_D_WRITE_SW 2'd3
`endif

interface riscv_lsu_if #(
    parameter int WRITE_LEN = `CACHE_D_WRITE_LEN
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_load;
    logic                 req_store;
    logic [2:0]           req_funct3;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic [4:0]           req_rd;
    logic                 cache_d_write_en;
    logic [WRITE_LEN-1:0] cache_d_write;
    logic [3:0]           cache_wmask;
    logic [31:0]          cache_addr;
    logic [31:0]          cache_wdata;
    logic [31:0]          cache_rdata;
    logic                 resp_valid;
    logic                 resp_err;
    logic [31:0]          resp_rdata;
    logic [4:0]           resp_rd;

    modport slave (
        input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, req_rd,
        input  cache_rdata,
        output req_ready,
        output cache_d_write_en, cache_d_write, cache_wmask, cache_addr, cache_wdata,
        output resp_valid, resp_err, resp_rdata, resp_rd
    );

    modport master (
        output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, req_rd,
        output cache_rdata,
        input  req_ready,
        input  cache_d_write_en, cache_d_write, cache_wmask, cache_addr, cache_wdata,
        input  resp_valid, resp_err, resp_rdata, resp_rd
    );
endinterface

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - MEM-stage load/store unit: alignment check, cache drive, load formatting
`ifndef CACHE_D_WRITE_LEN
`define CACHE_D_WRITE_LEN 2
`define CACHE_D_WRITE_SB 2'd1
`define CACHE_D_WRITE_SH 2'd2
`define CACHE_D_WRITE_SW 2'd3
`endif

module riscv_lsu #(
    parameter int LOAD_LATENCY = 1,
    parameter int WRITE_LEN    = `CACHE_D_WRITE_LEN
) (
    input logic        clk,
    input logic        rst,
    riscv_lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

    localparam logic [1:0] WAIT_LAST = (LOAD_LATENCY > 1) ? 2'(LOAD_LATENCY - 2) : 2'd0;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic        load_q;
    logic [1:0]  wait_cnt;
    logic        err_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic [4:0]  resp_rd_q;

    logic        f3_ok;
    logic        misaligned;
    logic        req_err;
    logic        accept;
    logic        store_issue;
    logic [3:0]  base_mask;
    logic [WRITE_LEN-1:0] write_code;
    logic [31:0] lane;
    logic [31:0] load_data;

    always_comb begin
        f3_ok = 1'b0;
        if (bus.req_load)
            f3_ok = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else
            f3_ok = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
        misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        req_err    = !f3_ok || (bus.req_load == bus.req_store) || misaligned;
    end

    assign accept        = bus.req_valid && (state == IDLE);
    assign bus.req_ready = (state == IDLE);

    // Write strobe is decoded from state so an async reset kills it without waiting for a clock.
    assign store_issue          = (state == ISSUE) && !load_q;
    assign bus.cache_d_write_en = store_issue;
    assign bus.cache_addr       = addr_q;
    assign bus.cache_wdata      = wdata_q << {addr_q[1:0], 3'b000};
    assign bus.cache_d_write    = write_code;

    always_comb begin
        base_mask  = 4'b1111;
        write_code = WRITE_LEN'(`CACHE_D_WRITE_SW);
        case (funct3_q[1:0])
            2'b00: begin
                base_mask  = 4'b0001;
                write_code = WRITE_LEN'(`CACHE_D_WRITE_SB);
            end
            2'b01: begin
                base_mask  = 4'b0011;
                write_code = WRITE_LEN'(`CACHE_D_WRITE_SH);
            end
            default: begin
                base_mask  = 4'b1111;
                write_code = WRITE_LEN'(`CACHE_D_WRITE_SW);
            end
        endcase
        bus.cache_wmask = store_issue ? (base_mask << addr_q[1:0]) : 4'b0000;
    end

    // Requests are alignment-checked on accept, so the shifted lane always holds the whole datum.
    always_comb begin
        lane = bus.cache_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_data = {24'b0, lane[7:0]};
            3'b101:  load_data = {16'b0, lane[15:0]};
            default: load_data = bus.cache_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            addr_q       <= 32'b0;
            wdata_q      <= 32'b0;
            funct3_q     <= 3'b0;
            rd_q         <= 5'b0;
            load_q       <= 1'b0;
            wait_cnt     <= 2'b0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'b0;
            resp_rd_q    <= 5'b0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'b0;
            resp_rd_q    <= 5'b0;
            err_q        <= 1'b0;
            if (err_q) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        funct3_q <= bus.req_funct3;
                        rd_q     <= bus.req_rd;
                        load_q   <= bus.req_load;
                        if (req_err)
                            err_q <= 1'b1;
                        else
                            state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!load_q) begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b1;
                    end else if (LOAD_LATENCY > 1) begin
                        state    <= WAIT;
                        wait_cnt <= 2'b0;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST)
                        state <= CAPTURE;
                    else
                        wait_cnt <= wait_cnt + 2'd1;
                end
                CAPTURE: begin
                    state        <= IDLE;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= load_data;
                    resp_rd_q    <= rd_q;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_rd    = resp_rd_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - scoreboard bench for riscv_lsu at load latencies 1 and 3
`ifndef CACHE_D_WRITE_LEN
`define CACHE_D_WRITE_LEN 2
`define CACHE_D_WRITE_SB 2'd1
`define CACHE_D_WRITE_SH 2'd2
`define CACHE_D_WRITE_SW 2'd3
`endif

module tb_riscv_lsu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    riscv_lsu_if b1 ();
    riscv_lsu_if b3 ();

    riscv_lsu #(.LOAD_LATENCY(1)) u_lat1 (.clk(clk), .rst(rst), .bus(b1.slave));
    riscv_lsu #(.LOAD_LATENCY(3)) u_lat3 (.clk(clk), .rst(rst), .bus(b3.slave));

    logic        sel = 1'b0;
    logic        req_valid = 1'b0, req_load = 1'b0, req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
    logic [4:0]  req_rd = 5'b0;

    assign b1.req_valid = req_valid & ~sel;
    assign b3.req_valid = req_valid & sel;
    assign b1.req_load = req_load;     assign b3.req_load = req_load;
    assign b1.req_store = req_store;   assign b3.req_store = req_store;
    assign b1.req_funct3 = req_funct3; assign b3.req_funct3 = req_funct3;
    assign b1.req_addr = req_addr;     assign b3.req_addr = req_addr;
    assign b1.req_wdata = req_wdata;   assign b3.req_wdata = req_wdata;
    assign b1.req_rd = req_rd;         assign b3.req_rd = req_rd;

    // Synchronous-read cache: word 0 holds the reference pattern, other words an address hash.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a[31:2] == 30'd0) ? 32'h80F1_7F82 : (a ^ 32'h5A5A_5A5A);
    endfunction
    logic [31:0] p1 = 32'b0, p3a = 32'b0, p3b = 32'b0, p3c = 32'b0;
    always @(posedge clk) begin
        p1  <= mem(b1.cache_addr);
        p3a <= mem(b3.cache_addr);
        p3b <= p3a;
        p3c <= p3b;
    end
    assign b1.cache_rdata = p1;
    assign b3.cache_rdata = p3c;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          due;
    } resp_t;
    typedef struct {
        logic [31:0] addr;
        logic [1:0]  code;
        logic [3:0]  mask;
        logic [31:0] wdata;
        int          due;
    } wr_t;
    resp_t rq0[$], rq1[$];
    wr_t   wq0[$], wq1[$];

    logic [1:0]  rv, rerr, wen, rdy;
    logic [31:0] rdat [2];
    logic [31:0] wa [2];
    logic [31:0] wd [2];
    logic [4:0]  rrd [2];
    logic [1:0]  wc [2];
    logic [3:0]  wm [2];
    assign rv   = {b3.resp_valid, b1.resp_valid};
    assign rerr = {b3.resp_err, b1.resp_err};
    assign wen  = {b3.cache_d_write_en, b1.cache_d_write_en};
    assign rdy  = {b3.req_ready, b1.req_ready};
    assign rdat[0] = b1.resp_rdata;    assign rdat[1] = b3.resp_rdata;
    assign rrd[0]  = b1.resp_rd;       assign rrd[1]  = b3.resp_rd;
    assign wa[0]   = b1.cache_addr;    assign wa[1]   = b3.cache_addr;
    assign wd[0]   = b1.cache_wdata;   assign wd[1]   = b3.cache_wdata;
    assign wc[0]   = b1.cache_d_write; assign wc[1]   = b3.cache_d_write;
    assign wm[0]   = b1.cache_wmask;   assign wm[1]   = b3.cache_wmask;

    resp_t er;
    wr_t   ew;
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                if (rv[i]) begin
                    if ((i == 0 && rq0.size() == 0) || (i == 1 && rq1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL dut%0d unexpected resp_valid at cycle %0d", i, cyc);
                    end else begin
                        er = (i == 0) ? rq0.pop_front() : rq1.pop_front();
                        chk($sformatf("dut%0d resp cycle", i), cyc, er.due);
                        chk($sformatf("dut%0d resp_err", i), rerr[i], er.err);
                        chk($sformatf("dut%0d resp_rdata", i), rdat[i], er.rdata);
                        chk($sformatf("dut%0d resp_rd", i), rrd[i], er.rd);
                    end
                end
                if (wen[i]) begin
                    if ((i == 0 && wq0.size() == 0) || (i == 1 && wq1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL dut%0d unexpected cache_d_write_en at cycle %0d", i, cyc);
                    end else begin
                        ew = (i == 0) ? wq0.pop_front() : wq1.pop_front();
                        chk($sformatf("dut%0d write cycle", i), cyc, ew.due);
                        chk($sformatf("dut%0d cache_addr", i), wa[i], ew.addr);
                        chk($sformatf("dut%0d cache_d_write", i), wc[i], ew.code);
                        chk($sformatf("dut%0d cache_wmask", i), wm[i], ew.mask);
                        chk($sformatf("dut%0d cache_wdata", i), wd[i], ew.wdata);
                    end
                end
                if (rdy[i]) begin
                    chk($sformatf("dut%0d idle wmask", i), wm[i], 4'b0);
                    chk($sformatf("dut%0d idle write_en", i), wen[i], 1'b0);
                end
            end
        end
    end

    // Waits for req_ready, accepts on the next edge and returns that edge's cycle number in acc.
    task automatic issue(input logic ld, input logic st, input logic [2:0] fn,
                         input logic [31:0] a, input logic [31:0] wdat, input logic [4:0] r,
                         input logic e_err, input logic [31:0] e_rdata, input logic [4:0] e_rd,
                         input logic [1:0] e_code, input logic [3:0] e_mask,
                         input logic [31:0] e_wdata, input int lat, output int acc);
        int idx = sel ? 1 : 0;
        resp_t r_e;
        wr_t   w_e;
        req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = fn;
        req_addr = a; req_wdata = wdat; req_rd = r;
        for (int n = 0; !rdy[idx]; n++) begin
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL req_ready timeout on dut%0d", idx);
                req_valid = 1'b0;
                acc = -1;
                return;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0;
        r_e.err = e_err; r_e.rdata = e_rdata; r_e.rd = e_rd; r_e.due = acc + lat;
        if (idx == 0) rq0.push_back(r_e); else rq1.push_back(r_e);
        if (e_mask != 4'b0) begin
            w_e.addr = a; w_e.code = e_code; w_e.mask = e_mask; w_e.wdata = e_wdata; w_e.due = acc;
            if (idx == 0) wq0.push_back(w_e); else wq1.push_back(w_e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int acc, acc2, n;
        repeat (3) @(posedge clk);
        #1;
        chk("reset resp_valid", b1.resp_valid, 1'b0);
        chk("reset req_ready", b1.req_ready, 1'b1);
        chk("reset write_en", b1.cache_d_write_en, 1'b0);
        chk("reset wmask", b1.cache_wmask, 4'b0);
        chk("reset cache_addr", b1.cache_addr, 32'h0);
        chk("reset resp_rdata", b1.resp_rdata, 32'h0);
        chk("reset resp_rd", b3.resp_rd, 5'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Stores and loads, latency 1
        issue(0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, 5'd7, 0, 32'h0, 5'd0, `CACHE_D_WRITE_SW, 4'b1111, 32'hDEAD_BEEF, 1, acc);
        issue(0, 1, 3'b000, 32'h13, 32'h0000_00A5, 5'd7, 0, 32'h0, 5'd0, `CACHE_D_WRITE_SB, 4'b1000, 32'hA500_0000, 1, acc);
        issue(0, 1, 3'b001, 32'h2,  32'h0000_1234, 5'd7, 0, 32'h0, 5'd0, `CACHE_D_WRITE_SH, 4'b1100, 32'h1234_0000, 1, acc);
        issue(1, 0, 3'b000, 32'h0, 32'h0, 5'd5, 0, 32'hFFFF_FF82, 5'd5, 2'd0, 4'b0, 32'h0, 2, acc);
        issue(1, 0, 3'b100, 32'h3, 32'h0, 5'd5, 0, 32'h0000_0080, 5'd5, 2'd0, 4'b0, 32'h0, 2, acc);
        issue(1, 0, 3'b001, 32'h2, 32'h0, 5'd5, 0, 32'hFFFF_80F1, 5'd5, 2'd0, 4'b0, 32'h0, 2, acc);
        issue(1, 0, 3'b010, 32'h0, 32'h0, 5'd5, 0, 32'h80F1_7F82, 5'd5, 2'd0, 4'b0, 32'h0, 2, acc);
        issue(1, 0, 3'b101, 32'h2, 32'h0, 5'd6, 0, 32'h0000_80F1, 5'd6, 2'd0, 4'b0, 32'h0, 2, acc);
        issue(1, 0, 3'b000, 32'h1, 32'h0, 5'd6, 0, 32'h0000_007F, 5'd6, 2'd0, 4'b0, 32'h0, 2, acc);

        // Error requests: no cache access, error response one cycle after accept
        issue(1, 0, 3'b010, 32'h6, 32'h0, 5'd5, 1, 32'h0, 5'd0, 2'd0, 4'b0, 32'h0, 1, acc);
        issue(0, 1, 3'b001, 32'h1, 32'hFFFF, 5'd5, 1, 32'h0, 5'd0, 2'd0, 4'b0, 32'h0, 1, acc);
        issue(1, 1, 3'b010, 32'h0, 32'h0, 5'd5, 1, 32'h0, 5'd0, 2'd0, 4'b0, 32'h0, 1, acc);
        issue(0, 0, 3'b010, 32'h0, 32'h0, 5'd5, 1, 32'h0, 5'd0, 2'd0, 4'b0, 32'h0, 1, acc);
        issue(1, 0, 3'b011, 32'h0, 32'h0, 5'd5, 1, 32'h0, 5'd0, 2'd0, 4'b0, 32'h0, 1, acc);
        issue(0, 1, 3'b100, 32'h0, 32'h0, 5'd5, 1, 32'h0, 5'd0, 2'd0, 4'b0, 32'h0, 1, acc);
        repeat (4) @(posedge clk);
        #1;

        // Async reset in the ISSUE cycle of a store
        req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("store write_en before reset", b1.cache_d_write_en, 1'b1);
        #1 rst = 1'b0;
        #1 chk("write_en drops on async reset", b1.cache_d_write_en, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        chk("req_ready after reset", b1.req_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("no resp after reset", b1.resp_valid, 1'b0);
        end

        // Latency 3: back-to-back store then load with req_valid held
        sel = 1'b1;
        issue(0, 1, 3'b010, 32'h10, 32'hCAFE_F00D, 5'd0, 0, 32'h0, 5'd0, `CACHE_D_WRITE_SW, 4'b1111, 32'hCAFE_F00D, 1, acc);
        issue(1, 0, 3'b010, 32'h0, 32'h0, 5'd9, 0, 32'h80F1_7F82, 5'd9, 2'd0, 4'b0, 32'h0, 4, acc2);
        chk("back-to-back accept spacing", acc2 - acc, 2);
        n = 0;
        while (!b3.req_ready && n < 10) begin
            n++;
            @(posedge clk); #1;
        end
        chk("req_ready low cycles lat3 load", n, 4);
        issue(1, 0, 3'b001, 32'h2,  32'h0, 5'd3, 0, 32'hFFFF_80F1, 5'd3, 2'd0, 4'b0, 32'h0, 4, acc);
        issue(1, 0, 3'b100, 32'h12, 32'h0, 5'd4, 0, 32'h0000_005A, 5'd4, 2'd0, 4'b0, 32'h0, 4, acc);
        repeat (8) @(posedge clk);
        #1;
        chk("responses drained", rq0.size() + rq1.size(), 0);
        chk("writes drained", wq0.size() + wq1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
